// File: rtl/mem_stage_if.sv
// Memory-port bundle between the MEM pipeline stage (master) and the memory system (slave).
`timescale 1ns/1ps
interface mem_stage_if;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ack;

   modport master (
      output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
      input  mem_rdata, mem_ack
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
      output mem_rdata, mem_ack
   );
endinterface

// File: rtl/mem_stage.sv
// MEM pipeline stage: big-endian byte/half/word loads and stores over a req/ack port,
// with a stall for the whole access, a misalign exception and a bus-timeout error.
`timescale 1ns/1ps
module mem_stage #(
   parameter int unsigned MEM_TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ex_valid,
   input  logic [31:0] ex_alu,
   input  logic [31:0] ex_rt,
   input  logic        ex_mem_rd,
   input  logic        ex_mem_wr,
   input  logic [1:0]  ex_size,
   input  logic        ex_sext,
   input  logic        ex_wb_en,
   input  logic [4:0]  ex_wb_addr,
   mem_stage_if.master mem,
   output logic        stall,
   output logic        misalign,
   output logic        bus_err,
   output logic        wb_valid,
   output logic        wb_en,
   output logic [4:0]  wb_addr,
   output logic [31:0] wb_data
);

   localparam int unsigned CNT_W = 10;

   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic [1:0]  lat_off;
   logic [1:0]  lat_size;
   logic        lat_sext;
   logic        lat_wb_en;
   logic [4:0]  lat_wb_addr;

   logic        mem_op_c, misaligned_c, start_c, misal_c, ack_c, timeout_c;
   logic [3:0]  be_c;
   logic [31:0] wdata_c;
   logic [7:0]  byte_c;
   logic [15:0] half_c;
   logic [31:0] load_c;

   // Gated by reset so stall/misalign read 0 while reset is held.
   assign mem_op_c     = rst & ex_valid & (ex_mem_rd | ex_mem_wr);
   assign misaligned_c = (ex_size == 2'b01) ? ex_alu[0] :
                         (ex_size[1] ? (|ex_alu[1:0]) : 1'b0);
   assign start_c      = (state_q == S_IDLE) & mem_op_c & ~misaligned_c;
   assign misal_c      = (state_q == S_IDLE) & mem_op_c & misaligned_c;
   assign ack_c        = (state_q == S_ACCESS) & mem.mem_ack;
   assign timeout_c    = (state_q == S_ACCESS) & ~mem.mem_ack &
                         (cnt_q == CNT_W'(MEM_TIMEOUT - 1));

   // Big-endian lane steering for the request being started.
   always_comb begin
      be_c    = 4'b1111;
      wdata_c = ex_rt;
      case (ex_size)
         2'b00: begin
            be_c    = 4'b1000 >> ex_alu[1:0];
            wdata_c = {4{ex_rt[7:0]}};
         end
         2'b01: begin
            be_c    = ex_alu[1] ? 4'b0011 : 4'b1100;
            wdata_c = {2{ex_rt[15:0]}};
         end
         default: begin
            be_c    = 4'b1111;
            wdata_c = ex_rt;
         end
      endcase
   end

   // Lane extraction and extension of returned read data.
   always_comb begin
      byte_c = 8'h00;
      case (lat_off)
         2'd0:    byte_c = mem.mem_rdata[31:24];
         2'd1:    byte_c = mem.mem_rdata[23:16];
         2'd2:    byte_c = mem.mem_rdata[15:8];
         default: byte_c = mem.mem_rdata[7:0];
      endcase
      half_c = lat_off[1] ? mem.mem_rdata[15:0] : mem.mem_rdata[31:16];
      case (lat_size)
         2'b00:   load_c = {{24{lat_sext & byte_c[7]}}, byte_c};
         2'b01:   load_c = {{16{lat_sext & half_c[15]}}, half_c};
         default: load_c = mem.mem_rdata;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      stall       = 1'b0;
      misalign    = 1'b0;
      mem.mem_req = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start_c) begin
               stall   = 1'b1;
               cnt_d   = '0;
               state_d = S_ACCESS;
            end else if (misal_c) begin
               misalign = 1'b1;
            end
         end
         S_ACCESS: begin
            mem.mem_req = 1'b1;
            stall       = 1'b1;
            if (ack_c || timeout_c) begin
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Request latches, MEM/WB result and bus-error pulse.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mem.mem_we    <= 1'b0;
         mem.mem_addr  <= '0;
         mem.mem_be    <= '0;
         mem.mem_wdata <= '0;
         lat_off       <= '0;
         lat_size      <= '0;
         lat_sext      <= 1'b0;
         lat_wb_en     <= 1'b0;
         lat_wb_addr   <= '0;
         bus_err       <= 1'b0;
         wb_valid      <= 1'b0;
         wb_en         <= 1'b0;
         wb_addr       <= '0;
         wb_data       <= '0;
      end else begin
         bus_err <= timeout_c;
         case (state_q)
            S_IDLE: begin
               if (start_c) begin
                  mem.mem_we    <= ex_mem_wr & ~ex_mem_rd;
                  mem.mem_addr  <= {ex_alu[31:2], 2'b00};
                  mem.mem_be    <= be_c;
                  mem.mem_wdata <= wdata_c;
                  lat_off       <= ex_alu[1:0];
                  lat_size      <= ex_size;
                  lat_sext      <= ex_sext;
                  lat_wb_en     <= ex_wb_en;
                  lat_wb_addr   <= ex_wb_addr;
                  wb_valid      <= 1'b0;
               end else if (misal_c) begin
                  wb_valid <= 1'b1;
                  wb_en    <= 1'b0;
                  wb_addr  <= ex_wb_addr;
               end else begin
                  wb_valid <= ex_valid;
                  wb_en    <= ex_wb_en & ex_valid;
                  wb_addr  <= ex_wb_addr;
                  wb_data  <= ex_alu;
               end
            end
            S_ACCESS: begin
               if (ack_c) begin
                  wb_valid <= 1'b1;
                  wb_addr  <= lat_wb_addr;
                  if (mem.mem_we) begin
                     wb_en <= 1'b0;
                  end else begin
                     wb_en   <= lat_wb_en;
                     wb_data <= load_c;
                  end
               end else if (timeout_c) begin
                  wb_valid <= 1'b1;
                  wb_en    <= 1'b0;
                  wb_addr  <= lat_wb_addr;
               end else begin
                  wb_valid <= 1'b0;
               end
            end
            default: wb_valid <= 1'b0;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: directed ops push expected bus/WB results, a monitor pops and compares.
`timescale 1ns/1ps
module tb_mem_stage;
   localparam int unsigned TMO = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        ex_valid = 1'b0;
   logic [31:0] ex_alu = '0;
   logic [31:0] ex_rt = '0;
   logic        ex_mem_rd = 1'b0;
   logic        ex_mem_wr = 1'b0;
   logic [1:0]  ex_size = '0;
   logic        ex_sext = 1'b0;
   logic        ex_wb_en = 1'b0;
   logic [4:0]  ex_wb_addr = '0;
   logic        stall, misalign, bus_err, wb_valid, wb_en;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;

   mem_stage_if bus ();

   mem_stage #(.MEM_TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_alu(ex_alu), .ex_rt(ex_rt),
      .ex_mem_rd(ex_mem_rd), .ex_mem_wr(ex_mem_wr), .ex_size(ex_size), .ex_sext(ex_sext),
      .ex_wb_en(ex_wb_en), .ex_wb_addr(ex_wb_addr), .mem(bus.master), .stall(stall),
      .misalign(misalign), .bus_err(bus_err), .wb_valid(wb_valid), .wb_en(wb_en),
      .wb_addr(wb_addr), .wb_data(wb_data)
   );

   always #5 clk = ~clk;

   typedef struct packed { logic en; logic [4:0] addr; logic [31:0] data; } wb_exp_t;
   typedef struct packed { logic we; logic [31:0] addr; logic [3:0] be; logic [31:0] wdata; } bus_exp_t;

   wb_exp_t  wb_q[$];
   bus_exp_t bus_q[$];
   int n_cmp = 0;
   int n_bad = 0;
   int misal_seen = 0;
   int berr_seen = 0;
   int req_seen = 0;

   // Memory model: ack after ack_wait ACCESS cycles unless suppressed.
   int          ack_wait = 0;
   int          wcnt = 0;
   logic        no_ack = 1'b0;
   logic        force_ack = 1'b0;
   logic [31:0] rd_val = '0;

   always @(posedge clk) begin
      #1;
      if (force_ack) begin
         bus.mem_ack = 1'b1;
      end else if (bus.mem_req && !no_ack && wcnt == ack_wait) begin
         bus.mem_ack   = 1'b1;
         bus.mem_rdata = rd_val;
         wcnt          = 0;
      end else begin
         bus.mem_ack = 1'b0;
         if (bus.mem_req && !no_ack) wcnt++;
         else wcnt = 0;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic monitor();
      wb_exp_t  w;
      bus_exp_t b;
      forever begin
         @(negedge clk);
         if (rst) begin
            misal_seen += int'(misalign);
            berr_seen  += int'(bus_err);
            req_seen   += int'(bus.mem_req);
            if (wb_valid) begin
               if (wb_q.size() == 0) begin
                  chk("wb_unexpected_valid", 32'(wb_valid), 32'd0);
               end else begin
                  w = wb_q.pop_front();
                  chk("wb_en", 32'(wb_en), 32'(w.en));
                  chk("wb_addr", 32'(wb_addr), 32'(w.addr));
                  if (w.en) chk("wb_data", wb_data, w.data);
               end
            end
            if (bus.mem_req && bus.mem_ack) begin
               if (bus_q.size() == 0) begin
                  chk("bus_unexpected_req", 32'(bus.mem_req), 32'd0);
               end else begin
                  b = bus_q.pop_front();
                  chk("mem_we", 32'(bus.mem_we), 32'(b.we));
                  chk("mem_addr", bus.mem_addr, b.addr);
                  chk("mem_be", 32'(bus.mem_be), 32'(b.be));
                  if (b.we) chk("mem_wdata", bus.mem_wdata, b.wdata);
               end
            end
         end
      end
   endtask

   task automatic settle();
      repeat (3) @(posedge clk);
      #2;
   endtask

   // Present one instruction and hold it until the stage consumes it (stall low at an edge).
   task automatic issue(input logic rd, input logic wr, input logic [1:0] sz, input logic sx,
                        input logic [31:0] alu, input logic [31:0] rt, input logic wen,
                        input logic [4:0] wa, output int stalls);
      logic done;
      ex_valid = 1'b1; ex_mem_rd = rd; ex_mem_wr = wr; ex_size = sz; ex_sext = sx;
      ex_alu = alu; ex_rt = rt; ex_wb_en = wen; ex_wb_addr = wa;
      stalls = 0;
      done = 1'b0;
      for (int i = 0; i < 40 && !done; i++) begin
         @(negedge clk);
         if (stall) stalls++;
         else done = 1'b1;
         @(posedge clk);
         #2;
      end
      if (!done) chk("issue_stall_bound", 32'(stall), 32'd0);
      ex_valid = 1'b0; ex_mem_rd = 1'b0; ex_mem_wr = 1'b0;
   endtask

   task automatic mem_op(input string nm, input logic rd, input logic wr, input logic [1:0] sz,
                         input logic sx, input logic [31:0] alu, input logic [31:0] rt,
                         input logic [31:0] rdv, input int wt, input logic [4:0] wa,
                         input logic ewe, input logic [31:0] eaddr, input logic [3:0] ebe,
                         input logic [31:0] ewdata, input logic ewen, input logic [31:0] edata,
                         input int estall);
      int st;
      rd_val = rdv;
      ack_wait = wt;
      bus_q.push_back('{we: ewe, addr: eaddr, be: ebe, wdata: ewdata});
      wb_q.push_back('{en: ewen, addr: wa, data: edata});
      issue(rd, wr, sz, sx, alu, rt, 1'b1, wa, st);
      chk({nm, "_stall_cycles"}, 32'(st), 32'(estall));
      settle();
   endtask

   initial begin
      int st, m0, r0, b0;
      fork
         monitor();
      join_none

      #3;
      chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
      chk("rst_mem_addr", bus.mem_addr, 32'd0);
      chk("rst_mem_be", 32'(bus.mem_be), 32'd0);
      chk("rst_stall", 32'(stall), 32'd0);
      chk("rst_wb_valid", 32'(wb_valid), 32'd0);
      chk("rst_wb_data", wb_data, 32'd0);
      chk("rst_bus_err", 32'(bus_err), 32'd0);
      #9 rst = 1'b1;
      @(posedge clk);
      #2;

      // ALU pass-through
      wb_q.push_back('{en: 1'b1, addr: 5'd7, data: 32'h1234_5678});
      issue(1'b0, 1'b0, 2'b10, 1'b0, 32'h1234_5678, 32'h0, 1'b1, 5'd7, st);
      chk("alu_stall_cycles", 32'(st), 32'd0);
      settle();

      mem_op("lb_s", 1'b1, 1'b0, 2'b00, 1'b1, 32'h0000_0101, 32'h0, 32'h11F0_2233, 2, 5'd3,
             1'b0, 32'h0000_0100, 4'b0100, 32'h0, 1'b1, 32'hFFFF_FFF0, 4);
      mem_op("lb_z", 1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_0101, 32'h0, 32'h11F0_2233, 2, 5'd4,
             1'b0, 32'h0000_0100, 4'b0100, 32'h0, 1'b1, 32'h0000_00F0, 4);
      mem_op("sh_o2", 1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_0202, 32'hAAAA_BEEF, 32'h0, 0, 5'd9,
             1'b1, 32'h0000_0200, 4'b0011, 32'hBEEF_BEEF, 1'b0, 32'h0, 2);
      mem_op("lh_s", 1'b1, 1'b0, 2'b01, 1'b1, 32'h0000_0300, 32'h0, 32'h8001_7FFF, 1, 5'd5,
             1'b0, 32'h0000_0300, 4'b1100, 32'h0, 1'b1, 32'hFFFF_8001, 3);
      mem_op("lw", 1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0404, 32'h0, 32'hDEAD_BEEF, 0, 5'd6,
             1'b0, 32'h0000_0404, 4'b1111, 32'h0, 1'b1, 32'hDEAD_BEEF, 2);
      mem_op("sb_o3", 1'b0, 1'b1, 2'b00, 1'b0, 32'h0000_0503, 32'h1234_5678, 32'h0, 1, 5'd10,
             1'b1, 32'h0000_0500, 4'b0001, 32'h7878_7878, 1'b0, 32'h0, 3);
      mem_op("lb_o3", 1'b1, 1'b0, 2'b00, 1'b1, 32'h0000_0603, 32'h0, 32'h0000_00A5, 0, 5'd11,
             1'b0, 32'h0000_0600, 4'b0001, 32'h0, 1'b1, 32'hFFFF_FFA5, 2);
      mem_op("rdwr_as_load", 1'b1, 1'b1, 2'b11, 1'b0, 32'h0000_0700, 32'hFFFF_FFFF, 32'h0BAD_F00D, 0,
             5'd12, 1'b0, 32'h0000_0700, 4'b1111, 32'h0, 1'b1, 32'h0BAD_F00D, 2);

      // Misaligned word load and half store: exception, no request
      m0 = misal_seen; r0 = req_seen;
      wb_q.push_back('{en: 1'b0, addr: 5'd13, data: 32'h0});
      issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0102, 32'h0, 1'b1, 5'd13, st);
      settle();
      chk("mis_w_stall", 32'(st), 32'd0);
      chk("mis_w_pulses", 32'(misal_seen - m0), 32'd1);
      chk("mis_w_req", 32'(req_seen - r0), 32'd0);
      m0 = misal_seen; r0 = req_seen;
      wb_q.push_back('{en: 1'b0, addr: 5'd14, data: 32'h0});
      issue(1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_0101, 32'h5555_5555, 1'b1, 5'd14, st);
      settle();
      chk("mis_h_pulses", 32'(misal_seen - m0), 32'd1);
      chk("mis_h_req", 32'(req_seen - r0), 32'd0);

      // Timeout: 4 ACCESS cycles without ack
      b0 = berr_seen; r0 = req_seen;
      no_ack = 1'b1;
      wb_q.push_back('{en: 1'b0, addr: 5'd15, data: 32'h0});
      issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0800, 32'h0, 1'b1, 5'd15, st);
      settle();
      no_ack = 1'b0;
      chk("tmo_stall_cycles", 32'(st), 32'd5);
      chk("tmo_bus_err_pulses", 32'(berr_seen - b0), 32'd1);
      chk("tmo_req_cycles", 32'(req_seen - r0), 32'd4);
      wb_q.push_back('{en: 1'b1, addr: 5'd16, data: 32'hCAFE_0001});
      issue(1'b0, 1'b0, 2'b00, 1'b0, 32'hCAFE_0001, 32'h0, 1'b1, 5'd16, st);
      chk("post_tmo_alu_stall", 32'(st), 32'd0);
      settle();

      // Stray ack while idle is ignored
      r0 = req_seen;
      force_ack = 1'b1;
      repeat (2) @(posedge clk);
      #2;
      force_ack = 1'b0;
      settle();
      chk("idle_ack_wb_valid", 32'(wb_valid), 32'd0);
      chk("idle_ack_req", 32'(req_seen - r0), 32'd0);

      // Reset in the middle of an access
      no_ack = 1'b1;
      ex_valid = 1'b1; ex_mem_rd = 1'b1; ex_mem_wr = 1'b0; ex_size = 2'b10;
      ex_alu = 32'h0000_0900; ex_wb_en = 1'b1; ex_wb_addr = 5'd17;
      repeat (2) @(posedge clk);
      #2;
      chk("mid_access_req", 32'(bus.mem_req), 32'd1);
      rst = 1'b0;
      ex_valid = 1'b0; ex_mem_rd = 1'b0;
      #1;
      chk("arst_mem_req", 32'(bus.mem_req), 32'd0);
      chk("arst_stall", 32'(stall), 32'd0);
      chk("arst_wb_valid", 32'(wb_valid), 32'd0);
      chk("arst_wb_en", 32'(wb_en), 32'd0);
      chk("arst_wb_addr", 32'(wb_addr), 32'd0);
      chk("arst_wb_data", wb_data, 32'd0);
      chk("arst_mem_addr", bus.mem_addr, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      no_ack = 1'b0;
      settle();

      chk("wb_queue_empty", 32'(wb_q.size()), 32'd0);
      chk("bus_queue_empty", 32'(bus_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access pipeline stage directly downstream of the integer datapath. Consumes the registered ALU result (address or arithmetic result) and the forwarded store data, performs byte/half/word loads and stores over a req/ack memory port with big-endian lane steering and sign/zero extension, and registers the MEM/WB result. It stalls the pipeline for the duration of every memory access. Its write-back output is the datapath's `MEM_WB_FWD` source.

## Interface
- `MEM_TIMEOUT`, 255: ACCESS cycles without `mem_ack` before a bus error is declared (1..1023).
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `ex_valid` in 1: the EX/MEM slot holds an instruction.
- `ex_alu` in 32: ALU result; the effective address for memory ops.
- `ex_rt` in 32: store data (forwarded RT).
- `ex_mem_rd` in 1: load.
- `ex_mem_wr` in 1: store. If both `ex_mem_rd` and `ex_mem_wr` are 1, the op is treated as a load.
- `ex_size` in 2: 00 byte, 01 half, 10/11 word.
- `ex_sext` in 1: sign-extend loads (0 = zero-extend).
- `ex_wb_en` in 1: instruction writes the regfile.
- `ex_wb_addr` in 5: destination register.
- `mem_req` out 1: access request, held until ack.
- `mem_we` out 1: 1 = write.
- `mem_addr` out 32: word address, `{addr[31:2],2'b00}`.
- `mem_be` out 4: byte enables; `be[3]` = bits 31:24.
- `mem_wdata` out 32: lane-replicated store data.
- `mem_rdata` in 32: read data, valid with `mem_ack`.
- `mem_ack` in 1: one-cycle completion strobe.
- `stall` out 1: freezes upstream stages and holds the `ex_*` inputs.
- `misalign` out 1: one-cycle pulse; address exception.
- `bus_err` out 1: one-cycle pulse; timeout.
- `wb_valid` out 1: registered, instruction retired this cycle.
- `wb_en` out 1: registered regfile write enable.
- `wb_addr` out 5: registered destination register.
- `wb_data` out 32: registered write-back data (MEM_WB_FWD).

## Operation
- A memory op is "start": `ex_valid & (ex_mem_rd | ex_mem_wr)` while in IDLE with an aligned address.
- The FSM has three states: IDLE, ACCESS and DONE.
- IDLE, non-memory op:
  - `wb_data <= ex_alu`, `wb_en <= ex_wb_en & ex_valid`, `wb_valid <= ex_valid`, `wb_addr <= ex_wb_addr`.
  - `stall` = 0.
- IDLE, start:
  - Latch address, size, sext, rd/wr, wb fields and steered store data.
  - `stall` = 1 (combinational, same cycle).
  - `wb_valid <= 0`; next state ACCESS.
- ACCESS:
  - `mem_req` = 1 and `stall` = 1.
  - `mem_addr`, `mem_we`, `mem_be` and `mem_wdata` are stable from latched values.
  - On `mem_ack`, for a load: `wb_data <= extended lane data`, `wb_en <= latched wb_en`.
  - On `mem_ack`, for a store: `wb_en <= 0`.
  - On `mem_ack`: `wb_valid <= 1`; next state DONE.
- DONE:
  - `stall` = 0 and `wb_valid <= 0`.
  - The held `ex_*` instruction is the one just retired and is not restarted.
  - Next state IDLE.
- Misalignment:
  - A half access is misaligned when `addr[0]`=1; a word access is misaligned when `addr[1:0]`≠0.
  - On start with a misaligned address, no request is issued. In that same cycle: `misalign` = 1 and `stall` = 0.
  - At the next edge: `wb_valid <= 1`, `wb_en <= 0`. The FSM stays in IDLE.
- Timeout: an ACCESS counter reaching `MEM_TIMEOUT` without ack produces the following at the next edge:
  - `bus_err` pulses; it is registered and high for the cycle after the edge.
  - `wb_en <= 0`, `wb_valid <= 1`; next state DONE.
  - A late ack is ignored.
- Lanes (big-endian): byte offset k maps to `be[3-k]`.
  - Byte store: `wdata = {4{rt[7:0]}}`.
  - Half store: `be` = 1100 for offset 0, 0011 for offset 2; `wdata = {2{rt[15:0]}}`.
  - Word store: `be` = 1111.
  - Load `be` equals the corresponding store `be`.
  - Loads extract the selected lane, then sign- or zero-extend it to 32 bits.
- `mem_ack` outside ACCESS is ignored.

## Timing
- Reset (asynchronous, while `rst`=0):
  - State is IDLE and the timeout counter is 0.
  - `mem_req`, `mem_we`, `mem_be`, `mem_addr`, `mem_wdata`, `stall`, `misalign`, `bus_err`, `wb_*` are all 0.
  - `mem_req` drops immediately. An access in flight is abandoned without write-back.
- Non-memory op: latency 1 cycle (visible on `wb_*` after the next edge), throughput 1 per cycle.
- Memory op with ack in the first ACCESS cycle:
  - start in cycle N, req in cycle N+1, `wb_*` valid in cycle N+2 (DONE, `stall`=0).
  - The upstream stage advances at the edge ending N+2.
  - Minimum 3 cycles per memory op. Each extra wait cycle adds 1.
- `stall` is combinational from the state and `ex_*` inputs. Upstream must hold `ex_*` constant while `stall`=1.
- `mem_req` deasserts in the cycle after the ack edge. Back-to-back requests are separated by at least 2 cycles.

## Test plan
- ALU pass-through: `ex_alu`=0x1234_5678, `ex_wb_en`=1, addr 7, no mem op → the next cycle shows `wb_valid`=1, `wb_en`=1, `wb_addr`=7, `wb_data`=0x1234_5678, and `stall` stays 0.
- Signed byte load at offset 1: addr 0x101, `mem_rdata`=0x11F0_2233, ack after 2 wait cycles → `mem_addr`=0x100, `be`=0100, `wb_data`=0xFFFF_FFF0, and `stall` is high for 4 cycles.
- Zero-extended byte load: same stimulus with `ex_sext`=0 → `wb_data`=0x0000_00F0.
- Half store at offset 2: `rt`=0xAAAA_BEEF → `mem_we`=1, `be`=0011, `wdata`=0xBEEF_BEEF, then `wb_en`=0 after the ack.
- Misaligned word load at addr 0x102 → `misalign` pulses for 1 cycle, `mem_req` never asserts, `wb_en`=0, and `stall`=0.
- No ack with `MEM_TIMEOUT`=4 → `bus_err` pulses once, `wb_en`=0, and the FSM returns to IDLE. A separate case asserts `rst`=0 mid-ACCESS → `mem_req`=0 immediately and all `wb_*`=0.
